serial_adder: RTL and testbench
===============================

Name: serial_adder

Overview:
- Multi-cycle, parametrised add/subtract unit built from a STEP-bit ripple slice of full-adder cells and a registered carry.
- Processes a WIDTH-bit operand pair LSB-first, STEP bits per cycle.
- Uses a valid/ready handshake on input and output.
- Sits in the arithmetic datapath as the area-cheap alternative to a full WIDTH-bit combinational adder.

Parameters:
- WIDTH, 8, operand/result width in bits (>=2).
- STEP, 1, bits processed per cycle. WIDTH % STEP must be 0; elaboration error otherwise.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous active-high reset
- in_valid  input  1  operands present
- in_ready  output  1  unit can accept operands (high only in IDLE)
- A  input  WIDTH  operand A (two's complement or unsigned)
- B  input  WIDTH  operand B
- Cin  input  1  carry-in (add) / borrow-in (subtract)
- Sub  input  1  0 = A+B+Cin, 1 = A-B-Cin
- out_valid  output  1  result available
- out_ready  input  1  consumer accepts result
- S  output  WIDTH  result
- Cout  output  1  raw carry out of MSB (in subtract mode, 1 = no borrow)
- Ovf  output  1  signed overflow

Behaviour:
- Clock and reset: one clock domain; rst is asynchronous, active-high.
- States: IDLE, RUN, DONE. Reset forces IDLE, step counter=0, carry=0, S=0, Cout=0, Ovf=0, out_valid=0.
- in_ready = (state==IDLE), combinational from state; it is 1 during and after reset.
- Accept: in_valid && in_ready at an edge. Latch A, Bx = Sub ? ~B : B, and carry = Sub ? ~Cin : Cin. Zero the step counter and go to RUN.
  - A, B, Cin, Sub are sampled only at accept; later changes are ignored.
- RUN, each cycle:
  - Slice bits [STEP*k +: STEP] of A and Bx through a STEP-bit ripple of full adders (sum = a^b^c, carry = ab|bc|ca), seeded with the registered carry.
  - Write the sum bits into the internal result shift register.
  - Update the registered carry; increment k.
- On the last step (k = WIDTH/STEP-1):
  - Record carry into MSB (c_msb) and carry out of MSB (c_out).
  - Load the output registers: S = result, Cout = c_out, Ovf = c_msb ^ c_out.
  - Go to DONE; out_valid=1.
- Latency: accept at edge N -> out_valid high after edge N + WIDTH/STEP. WIDTH=8, STEP=1 gives 8 cycles; STEP=8 gives 1 cycle.
- DONE: out_valid=1. S/Cout/Ovf held stable while out_ready=0 (unbounded backpressure).
  - out_valid && out_ready at an edge -> IDLE, out_valid=0.
  - in_ready rises the same cycle (combinational from state); there is no same-edge accept-while-DONE bypass.
- S/Cout/Ovf change only when a new result completes; between results they hold the previous result. They are 0 after reset.
- Throughput: one operation per WIDTH/STEP + 2 cycles at best.
- in_valid asserted while not in IDLE: ignored, no effect.
- out_ready asserted while not in DONE: ignored.
- Reset mid-RUN or mid-DONE: immediate abort to reset values. The partial result is discarded and no out_valid pulse occurs.
- Arithmetic wraps modulo 2^WIDTH. No saturation.

Test Plan:
- WIDTH=8, STEP=1, Sub=0: A=0x5A, B=0x3C, Cin=0 -> out_valid exactly 8 cycles after accept; S=0x96, Cout=0, Ovf=1.
- Wrap and carry: A=0xFF, B=0x01, Cin=0 -> S=0x00, Cout=1, Ovf=0. A=0x7F, B=0x00, Cin=1 -> S=0x80, Cout=0, Ovf=1.
- Subtract: A=0x10, B=0x20, Sub=1, Cin=0 -> S=0xF0, Cout=0, Ovf=0. A=0x80, B=0x01, Sub=1 -> S=0x7F, Cout=1, Ovf=1. A=0x05, B=0x02, Sub=1, Cin=1 -> S=0x02, Cout=1.
- Handshake:
  - Hold out_ready=0 for 5 cycles in DONE -> S/Cout/Ovf/out_valid stable; in_ready=0 throughout.
  - Toggle A/B during RUN -> result unaffected.
  - in_valid during RUN -> not accepted.
- Reset: assert rst at RUN step 3 -> all outputs 0 and in_ready=1 immediately; no out_valid. A fresh op after release completes normally.
- Parameter sweep: WIDTH=4 with STEP=1, 2, 4 -> exhaustive A, B, Cin, Sub (1024 cases) against a behavioural model; latency = 4, 2, 1 cycles respectively.

Source files
------------

// File: rtl/serial_adder_if.sv
`default_nettype none
// ============================================================================
// Module   : serial_adder_if
// Purpose  : Operand/result handshake bundle for the serial add/subtract unit.
// Revision : 1.0 - initial release
// ============================================================================
interface serial_adder_if #(
    parameter int WIDTH = 8
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic             Cin;
    logic             Sub;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] S;
    logic             Cout;
    logic             Ovf;

    modport master (
        output in_valid,
        output A,
        output B,
        output Cin,
        output Sub,
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  S,
        input  Cout,
        input  Ovf
    );

    modport slave (
        input  in_valid,
        input  A,
        input  B,
        input  Cin,
        input  Sub,
        input  out_ready,
        output in_ready,
        output out_valid,
        output S,
        output Cout,
        output Ovf
    );
endinterface
`default_nettype wire

// File: rtl/serial_adder.sv
`default_nettype none
// ============================================================================
// Module   : serial_adder
// Purpose  : Multi-cycle add/subtract, LSB-first, STEP bits per cycle through
//            a ripple slice with a registered carry between slices.
// Revision : 1.0 - initial release
// ============================================================================
module serial_adder #(
    parameter int WIDTH = 8,
    parameter int STEP  = 1
) (
    input  logic          clk,
    input  logic          rst,
    serial_adder_if.slave bus
);

    localparam int c_num_steps = WIDTH / STEP;
    localparam int c_cnt_w     = (c_num_steps > 1) ? $clog2(c_num_steps) : 1;
    localparam logic [c_cnt_w-1:0] c_last_step = c_cnt_w'(c_num_steps - 1);

    generate
        if (WIDTH < 2) begin : g_bad_width
            $error("serial_adder: WIDTH must be at least 2");
        end
        if ((STEP < 1) || (STEP > WIDTH) || ((WIDTH % STEP) != 0)) begin : g_bad_step
            $error("serial_adder: STEP must divide WIDTH evenly");
        end
    endgenerate

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t             r_state;
    state_t             w_state_next;

    logic [WIDTH-1:0]   r_a;
    logic [WIDTH-1:0]   r_bx;
    logic               r_carry;
    logic [c_cnt_w-1:0] r_cnt;
    logic [WIDTH-1:0]   r_result;
    logic [WIDTH-1:0]   r_s;
    logic               r_cout;
    logic               r_ovf;

    logic               w_in_ready;
    logic               w_out_valid;
    logic               w_accept;
    logic               w_step;
    logic               w_finish;
    logic               w_last;
    int                 w_base;
    logic [STEP-1:0]    w_slice_a;
    logic [STEP-1:0]    w_slice_b;
    logic [STEP-1:0]    w_sum;
    logic [STEP:0]      w_c;
    logic [WIDTH-1:0]   w_result_next;

    // ------------------------------------------------------------------
    // Control FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    assign w_last = (r_cnt == c_last_step);

    always_comb begin
        w_state_next = r_state;
        w_in_ready   = 1'b0;
        w_out_valid  = 1'b0;
        w_accept     = 1'b0;
        w_step       = 1'b0;
        w_finish     = 1'b0;
        case (r_state)
            ST_IDLE: begin
                w_in_ready = 1'b1;
                if (bus.in_valid) begin
                    w_accept     = 1'b1;
                    w_state_next = ST_RUN;
                end
            end
            ST_RUN: begin
                w_step = 1'b1;
                if (w_last) begin
                    w_finish     = 1'b1;
                    w_state_next = ST_DONE;
                end
            end
            ST_DONE: begin
                w_out_valid = 1'b1;
                if (bus.out_ready) begin
                    w_state_next = ST_IDLE;
                end
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Ripple slice: STEP full adders seeded by the registered carry
    // ------------------------------------------------------------------
    assign w_base    = int'(r_cnt) * STEP;
    assign w_slice_a = r_a[w_base +: STEP];
    assign w_slice_b = r_bx[w_base +: STEP];
    assign w_c[0]    = r_carry;

    generate
        for (genvar i = 0; i < STEP; i++) begin : g_ripple
            assign w_sum[i]   = w_slice_a[i] ^ w_slice_b[i] ^ w_c[i];
            assign w_c[i+1]   = (w_slice_a[i] & w_slice_b[i])
                              | (w_slice_b[i] & w_c[i])
                              | (w_c[i] & w_slice_a[i]);
        end
    endgenerate

    always_comb begin
        w_result_next                  = r_result;
        w_result_next[w_base +: STEP]  = w_sum;
    end

    // ------------------------------------------------------------------
    // Datapath registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_a      <= '0;
            r_bx     <= '0;
            r_carry  <= 1'b0;
            r_cnt    <= '0;
            r_result <= '0;
            r_s      <= '0;
            r_cout   <= 1'b0;
            r_ovf    <= 1'b0;
        end else if (w_accept) begin
            // Subtraction is A + ~B + ~borrow, so invert once at capture
            r_a     <= bus.A;
            r_bx    <= bus.Sub ? ~bus.B : bus.B;
            r_carry <= bus.Sub ? ~bus.Cin : bus.Cin;
            r_cnt   <= '0;
        end else if (w_step) begin
            r_result <= w_result_next;
            r_carry  <= w_c[STEP];
            if (w_finish) begin
                r_cnt  <= '0;
                r_s    <= w_result_next;
                r_cout <= w_c[STEP];
                r_ovf  <= w_c[STEP-1] ^ w_c[STEP];
            end else begin
                r_cnt  <= r_cnt + c_cnt_w'(1);
            end
        end
    end

    assign bus.in_ready  = w_in_ready;
    assign bus.out_valid = w_out_valid;
    assign bus.S         = r_s;
    assign bus.Cout      = r_cout;
    assign bus.Ovf       = r_ovf;

endmodule
`default_nettype wire

// File: tb/tb_serial_adder.sv
`default_nettype none
// ============================================================================
// Module   : tb_serial_adder
// Purpose  : Directed + exhaustive scoreboard bench for serial_adder.
// Revision : 1.0 - initial release
// ============================================================================
module tb_serial_adder;

    logic clk = 1'b0;
    logic rst;
    int   n_cmp  = 0;
    int   n_fail = 0;

    always #5 clk = ~clk;

    serial_adder_if #(.WIDTH(8)) b8  ();
    serial_adder_if #(.WIDTH(4)) b41 ();
    serial_adder_if #(.WIDTH(4)) b42 ();
    serial_adder_if #(.WIDTH(4)) b44 ();

    serial_adder #(.WIDTH(8), .STEP(1)) dut8  (.clk(clk), .rst(rst), .bus(b8.slave));
    serial_adder #(.WIDTH(4), .STEP(1)) dut41 (.clk(clk), .rst(rst), .bus(b41.slave));
    serial_adder #(.WIDTH(4), .STEP(2)) dut42 (.clk(clk), .rst(rst), .bus(b42.slave));
    serial_adder #(.WIDTH(4), .STEP(4)) dut44 (.clk(clk), .rst(rst), .bus(b44.slave));

    logic [9:0] q8[$];
    logic [5:0] q41[$];
    logic [5:0] q42[$];
    logic [5:0] q44[$];
    logic [9:0] last8;
    logic [5:0] e4;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic fail(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_fail++;
        $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
    endtask

    function automatic logic [9:0] model(input int w, input int a, input int b,
                                         input bit cin, input bit sub);
        int mask, bx, full, s;
        bit cout, ovf, sa, sb, ss, c0;
        mask = (1 << w) - 1;
        bx   = sub ? (~b & mask) : (b & mask);
        c0   = sub ? !cin : cin;
        full = (a & mask) + bx + (c0 ? 1 : 0);
        s    = full & mask;
        cout = ((full >> w) & 1) != 0;
        sa   = ((a  >> (w - 1)) & 1) != 0;
        sb   = ((bx >> (w - 1)) & 1) != 0;
        ss   = ((s  >> (w - 1)) & 1) != 0;
        ovf  = (sa == sb) && (ss != sa);
        return {cout, ovf, 8'(s)};
    endfunction

    task automatic op8(input string tag, input logic [7:0] a, input logic [7:0] b,
                       input logic cin, input logic sub, input logic [9:0] expv,
                       input bit disturb, input bit backpressure);
        int         cyc;
        logic [9:0] e;
        q8.push_back(expv);
        b8.A = a; b8.B = b; b8.Cin = cin; b8.Sub = sub; b8.in_valid = 1'b1;
        tick();
        b8.in_valid = 1'b0;
        cyc = 0;
        while (b8.out_valid !== 1'b1 && cyc < 40) begin
            n_cmp++;
            if ({b8.Cout, b8.Ovf, b8.S} !== last8)
                fail({tag, " hold"}, {b8.Cout, b8.Ovf, b8.S}, last8);
            n_cmp++;
            if (b8.in_ready !== 1'b0)
                fail({tag, " in_ready run"}, b8.in_ready, 1'b0);
            if (disturb) begin
                b8.A = 8'($urandom); b8.B = 8'($urandom);
                b8.Cin = 1'($urandom); b8.Sub = 1'($urandom);
                b8.in_valid = 1'b1;
            end
            tick();
            cyc++;
        end
        b8.in_valid = 1'b0;
        n_cmp++;
        if (cyc != 8)
            fail({tag, " latency"}, cyc, 8);
        n_cmp++;
        if (q8.size() == 0)
            fail({tag, " sb"}, 0, 1);
        e = (q8.size() > 0) ? q8.pop_front() : 10'h0;
        n_cmp++;
        if ({b8.Cout, b8.Ovf, b8.S} !== e)
            fail({tag, " result"}, {b8.Cout, b8.Ovf, b8.S}, e);
        last8 = e;
        if (backpressure) begin
            for (int k = 0; k < 5; k++) begin
                b8.in_valid = 1'b1;
                tick();
                n_cmp++;
                if (b8.out_valid !== 1'b1)
                    fail({tag, " bp valid"}, b8.out_valid, 1'b1);
                n_cmp++;
                if (b8.in_ready !== 1'b0)
                    fail({tag, " bp in_ready"}, b8.in_ready, 1'b0);
                n_cmp++;
                if ({b8.Cout, b8.Ovf, b8.S} !== e)
                    fail({tag, " bp result"}, {b8.Cout, b8.Ovf, b8.S}, e);
            end
            b8.in_valid = 1'b0;
        end
        b8.out_ready = 1'b1;
        tick();
        b8.out_ready = 1'b0;
        n_cmp++;
        if (b8.out_valid !== 1'b0)
            fail({tag, " drained"}, b8.out_valid, 1'b0);
        n_cmp++;
        if (b8.in_ready !== 1'b1)
            fail({tag, " in_ready idle"}, b8.in_ready, 1'b1);
        n_cmp++;
        if ({b8.Cout, b8.Ovf, b8.S} !== e)
            fail({tag, " kept"}, {b8.Cout, b8.Ovf, b8.S}, e);
    endtask

    initial begin
        logic [7:0] ra, rb;
        logic       rc, rs;
        logic [9:0] ex;
        bit         s1, s2, s4;
        int         l1, l2, l4;

        rst = 1'b1;
        last8 = 10'h0;
        b8.in_valid = 0;  b8.out_ready = 0;  b8.A = 0;  b8.B = 0;  b8.Cin = 0;  b8.Sub = 0;
        b41.in_valid = 0; b41.out_ready = 0; b41.A = 0; b41.B = 0; b41.Cin = 0; b41.Sub = 0;
        b42.in_valid = 0; b42.out_ready = 0; b42.A = 0; b42.B = 0; b42.Cin = 0; b42.Sub = 0;
        b44.in_valid = 0; b44.out_ready = 0; b44.A = 0; b44.B = 0; b44.Cin = 0; b44.Sub = 0;
        tick();
        tick();

        n_cmp++;
        if (b8.in_ready !== 1'b1)
            fail("reset in_ready", b8.in_ready, 1'b1);
        n_cmp++;
        if (b8.out_valid !== 1'b0)
            fail("reset out_valid", b8.out_valid, 1'b0);
        n_cmp++;
        if ({b8.Cout, b8.Ovf, b8.S} !== 10'h0)
            fail("reset outputs", {b8.Cout, b8.Ovf, b8.S}, 10'h0);
        n_cmp++;
        if ({b41.out_valid, b42.out_valid, b44.out_valid, b41.S, b42.S, b44.S} !== 15'h0)
            fail("reset w4 outputs",
                 {b41.out_valid, b42.out_valid, b44.out_valid, b41.S, b42.S, b44.S}, 15'h0);
        rst = 1'b0;
        tick();

        op8("add 5a+3c",   8'h5A, 8'h3C, 1'b0, 1'b0, {1'b0, 1'b1, 8'h96}, 0, 0);
        op8("wrap ff+01",  8'hFF, 8'h01, 1'b0, 1'b0, {1'b1, 1'b0, 8'h00}, 0, 0);
        op8("7f+00+c",     8'h7F, 8'h00, 1'b1, 1'b0, {1'b0, 1'b1, 8'h80}, 0, 0);
        op8("sub 10-20",   8'h10, 8'h20, 1'b0, 1'b1, {1'b0, 1'b0, 8'hF0}, 0, 0);
        op8("sub 80-01",   8'h80, 8'h01, 1'b0, 1'b1, {1'b1, 1'b1, 8'h7F}, 0, 0);
        op8("sub 05-02-b", 8'h05, 8'h02, 1'b1, 1'b1, {1'b1, 1'b0, 8'h02}, 0, 0);
        op8("backpressure", 8'hC3, 8'h4E, 1'b0, 1'b0, {1'b1, 1'b0, 8'h11}, 0, 1);
        op8("disturb run", 8'h64, 8'h64, 1'b0, 1'b0, {1'b0, 1'b1, 8'hC8}, 1, 0);

        for (int k = 0; k < 6; k++) begin
            ra = 8'($urandom); rb = 8'($urandom);
            rc = 1'($urandom); rs = 1'($urandom);
            op8("random", ra, rb, rc, rs, model(8, int'(ra), int'(rb), rc, rs), 0, 0);
        end

        q8.push_back(model(8, 8'h33, 8'h44, 1'b0, 1'b0));
        b8.A = 8'h33; b8.B = 8'h44; b8.Cin = 0; b8.Sub = 0; b8.in_valid = 1'b1;
        tick();
        b8.in_valid = 1'b0;
        tick(); tick(); tick();
        rst = 1'b1;
        #1;
        n_cmp++;
        if (b8.in_ready !== 1'b1)
            fail("abort in_ready", b8.in_ready, 1'b1);
        n_cmp++;
        if (b8.out_valid !== 1'b0)
            fail("abort out_valid", b8.out_valid, 1'b0);
        n_cmp++;
        if ({b8.Cout, b8.Ovf, b8.S} !== 10'h0)
            fail("abort outputs", {b8.Cout, b8.Ovf, b8.S}, 10'h0);
        void'(q8.pop_back());
        last8 = 10'h0;
        tick(); tick();
        rst = 1'b0;
        for (int k = 0; k < 12; k++) begin
            tick();
            n_cmp++;
            if (b8.out_valid !== 1'b0)
                fail("abort no pulse", b8.out_valid, 1'b0);
        end
        op8("after abort", 8'h21, 8'h12, 1'b0, 1'b0, {1'b0, 1'b0, 8'h33}, 0, 0);

        for (int i = 0; i < 1024; i++) begin
            ex = model(4, i & 15, (i >> 4) & 15, i[8], i[9]);
            q41.push_back({ex[9:8], ex[3:0]});
            q42.push_back({ex[9:8], ex[3:0]});
            q44.push_back({ex[9:8], ex[3:0]});
            b41.A = 4'(i); b41.B = 4'(i >> 4); b41.Cin = i[8]; b41.Sub = i[9];
            b42.A = 4'(i); b42.B = 4'(i >> 4); b42.Cin = i[8]; b42.Sub = i[9];
            b44.A = 4'(i); b44.B = 4'(i >> 4); b44.Cin = i[8]; b44.Sub = i[9];
            b41.in_valid = 1'b1; b42.in_valid = 1'b1; b44.in_valid = 1'b1;
            tick();
            b41.in_valid = 1'b0; b42.in_valid = 1'b0; b44.in_valid = 1'b0;
            s1 = 0; s2 = 0; s4 = 0; l1 = 0; l2 = 0; l4 = 0;
            for (int c = 1; c <= 8 && !(s1 && s2 && s4); c++) begin
                tick();
                if (!s1 && b41.out_valid === 1'b1) begin
                    s1 = 1'b1;
                    l1 = c;
                    n_cmp++;
                    if (q41.size() == 0) begin
                        fail("w4s1 sb", 0, 1);
                    end else begin
                        e4 = q41.pop_front();
                        n_cmp++;
                        if ({b41.Cout, b41.Ovf, b41.S} !== e4)
                            fail("w4s1 result", {b41.Cout, b41.Ovf, b41.S}, e4);
                    end
                end
                if (!s2 && b42.out_valid === 1'b1) begin
                    s2 = 1'b1;
                    l2 = c;
                    n_cmp++;
                    if (q42.size() == 0) begin
                        fail("w4s2 sb", 0, 1);
                    end else begin
                        e4 = q42.pop_front();
                        n_cmp++;
                        if ({b42.Cout, b42.Ovf, b42.S} !== e4)
                            fail("w4s2 result", {b42.Cout, b42.Ovf, b42.S}, e4);
                    end
                end
                if (!s4 && b44.out_valid === 1'b1) begin
                    s4 = 1'b1;
                    l4 = c;
                    n_cmp++;
                    if (q44.size() == 0) begin
                        fail("w4s4 sb", 0, 1);
                    end else begin
                        e4 = q44.pop_front();
                        n_cmp++;
                        if ({b44.Cout, b44.Ovf, b44.S} !== e4)
                            fail("w4s4 result", {b44.Cout, b44.Ovf, b44.S}, e4);
                    end
                end
            end
            if (!s1 && q41.size() > 0) void'(q41.pop_front());
            if (!s2 && q42.size() > 0) void'(q42.pop_front());
            if (!s4 && q44.size() > 0) void'(q44.pop_front());
            n_cmp++;
            if (l1 != 4)
                fail("w4s1 latency", l1, 4);
            n_cmp++;
            if (l2 != 2)
                fail("w4s2 latency", l2, 2);
            n_cmp++;
            if (l4 != 1)
                fail("w4s4 latency", l4, 1);
            b41.out_ready = 1'b1; b42.out_ready = 1'b1; b44.out_ready = 1'b1;
            tick();
            b41.out_ready = 1'b0; b42.out_ready = 1'b0; b44.out_ready = 1'b0;
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish, observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
